// File: rtl/dcache_ctrl_if.sv
// Memory-side valid/ready bus between the data cache controller and main memory.
// master = cache side, slave = memory side.
interface dcache_ctrl_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache for the M stage.
// Optional hit/miss counters are enabled with the DCACHE_STATS_EN macro.
module dcache_ctrl #(
    parameter int SETS  = 8,
    parameter int IDX_W = $clog2(SETS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [31:0]   AddrM,
    input  logic [31:0]   WriteDataM,
    input  logic          MemReadM,
    input  logic          MemWriteM,
    output logic [31:0]   ReadDataM,
    output logic          StallMemReq,
    dcache_ctrl_if.master mem
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]   hit_count,
    output logic [31:0]   miss_count
`endif
);
    localparam int TAG_W = 30 - IDX_W;

    typedef enum logic [1:0] {IDLE, FILL, WRITE, WDONE} state_t;

    state_t           state_reg;
    state_t           state_next;
    logic             mem_req_reg;
    logic             mem_we_reg;
    logic [31:0]      mem_addr_reg;
    logic [31:0]      mem_wdata_reg;

    logic             valid_reg [SETS];
    logic [TAG_W-1:0] tag_mem   [SETS];
    logic [31:0]      data_mem  [SETS];

    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] tag;
    logic [TAG_W-1:0] req_tag;
    logic             hit;
    logic             req_hit;
    logic             is_load;
    logic             is_store;
    logic             xfer_done;
    logic             fill_we;
    logic             store_we;
    logic             start_req;
    logic [31:0]      read_data;
    logic             stall;
    logic             unused_addr_bits;

    assign idx      = AddrM[IDX_W+1:2];
    assign tag      = AddrM[31:IDX_W+2];
    assign req_idx  = mem_addr_reg[IDX_W+1:2];
    assign req_tag  = mem_addr_reg[31:IDX_W+2];
    assign hit      = valid_reg[idx] && (tag_mem[idx] == tag);
    assign req_hit  = valid_reg[req_idx] && (tag_mem[req_idx] == req_tag);
    assign is_store = MemWriteM;
    assign is_load  = MemReadM && !MemWriteM;

    assign unused_addr_bits = ^AddrM[1:0];

    // A response only counts while a request is outstanding.
    assign xfer_done = mem_req_reg && mem.mem_ready;
    assign fill_we   = (state_reg == FILL) && xfer_done;
    assign store_we  = (state_reg == WRITE) && xfer_done && req_hit;
    assign start_req = (state_reg == IDLE) && (state_next != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        stall      = 1'b0;
        read_data  = 32'h0;
        case (state_reg)
            IDLE: begin
                if (is_store) begin
                    stall      = 1'b1;
                    state_next = WRITE;
                end else if (is_load) begin
                    if (hit) begin
                        read_data = data_mem[idx];
                    end else begin
                        stall      = 1'b1;
                        state_next = FILL;
                    end
                end
            end
            FILL: begin
                stall = 1'b1;
                if (xfer_done) state_next = IDLE;
            end
            WRITE: begin
                stall = 1'b1;
                if (xfer_done) state_next = WDONE;
            end
            WDONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Request fields are captured once on leaving IDLE and held until accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_req_reg   <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= 32'h0;
            mem_wdata_reg <= 32'h0;
        end else if (start_req) begin
            mem_req_reg  <= 1'b1;
            mem_we_reg   <= is_store;
            mem_addr_reg <= {AddrM[31:2], 2'b00};
            if (is_store) mem_wdata_reg <= WriteDataM;
        end else if (xfer_done) begin
            mem_req_reg <= 1'b0;
            mem_we_reg  <= 1'b0;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < SETS; gi++) begin : g_line
            always_ff @(posedge clk) begin
                if (rst) begin
                    valid_reg[gi] <= 1'b0;
                end else if (fill_we && (req_idx == IDX_W'(gi))) begin
                    valid_reg[gi] <= 1'b1;
                end
            end
        end
    endgenerate

    // Tag/data arrays carry no reset; valid bits gate every use.
    always_ff @(posedge clk) begin
        if (fill_we) begin
            tag_mem[req_idx]  <= req_tag;
            data_mem[req_idx] <= mem.mem_rdata;
        end else if (store_we) begin
            data_mem[req_idx] <= mem_wdata_reg;
        end
    end

    assign ReadDataM     = read_data;
    assign StallMemReq   = stall;
    assign mem.mem_req   = mem_req_reg;
    assign mem.mem_we    = mem_we_reg;
    assign mem.mem_addr  = mem_addr_reg;
    assign mem.mem_wdata = mem_wdata_reg;

`ifdef DCACHE_STATS_EN
    state_t      prev_state_reg;
    logic [31:0] hit_count_reg;
    logic [31:0] miss_count_reg;

    // The replay of a just-filled load is not a new hit.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_state_reg <= IDLE;
            hit_count_reg  <= 32'h0;
            miss_count_reg <= 32'h0;
        end else begin
            prev_state_reg <= state_reg;
            if ((state_reg == IDLE) && (state_next == FILL)) begin
                miss_count_reg <= miss_count_reg + 32'd1;
            end
            if ((state_reg == IDLE) && is_load && hit && (prev_state_reg != FILL)) begin
                hit_count_reg <= hit_count_reg + 32'd1;
            end
        end
    end

    assign hit_count  = hit_count_reg;
    assign miss_count = miss_count_reg;
`endif
endmodule
